// File: rtl/button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_debounce: sync + counter debounce of an active-low push button with   |
// | press/release/long/repeat strobes.                            Rev 1.0        |
// +----------------------------------------------------------------------------+
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_WAIT = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG       = 3'd3,
    ST_REL_WAIT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             was_long_q, was_long_d;
  logic             pressed_q, pressed_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             btn_s;

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], ~btn_n};
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    was_long_d = was_long_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        db_cnt_d = '0;
        if (btn_s) begin
          state_d  = ST_PRESS_WAIT;
          db_cnt_d = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_HELD;
          pressed_d  = 1'b1;
          press_d    = 1'b1;
          hold_cnt_d = '0;
          was_long_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      // A release sample outranks the long/repeat terminal counts.
      ST_HELD: begin
        if (!btn_s) begin
          state_d  = ST_REL_WAIT;
          db_cnt_d = CNT_ONE;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d    = ST_LONG;
          long_d     = 1'b1;
          rep_cnt_d  = '0;
          was_long_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end
      ST_LONG: begin
        if (!btn_s) begin
          state_d  = ST_REL_WAIT;
          db_cnt_d = CNT_ONE;
        end else if (rep_cnt_q == REP_LAST) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
      end
      // Hold/repeat counters stay frozen so a release glitch only delays them.
      ST_REL_WAIT: begin
        if (btn_s) begin
          state_d = was_long_q ? ST_LONG : ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          db_cnt_d  = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      was_long_q <= 1'b0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      was_long_q <= was_long_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// Scoreboard bench for button_debounce: stimulus queues expected strobes/levels
// by edge number, a negedge monitor pops and compares them.
module tb_button_debounce;

  localparam logic [3:0] S_PRESS = 4'b1000;
  localparam logic [3:0] S_REL   = 4'b0100;
  localparam logic [3:0] S_LONG  = 4'b0010;
  localparam logic [3:0] S_REP   = 4'b0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int cyc = 0;
  bit done = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] mon_s;

  typedef struct {int cyc; logic [3:0] s;} strobe_t;
  typedef struct {int cyc; logic v;} level_t;
  strobe_t sq[$];
  level_t  lq[$];

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(5),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_strobe(input int c, input logic [3:0] s);
    strobe_t e;
    e.cyc = c;
    e.s   = s;
    sq.push_back(e);
  endtask

  task automatic exp_level(input int c, input logic v);
    level_t e;
    e.cyc = c;
    e.v   = v;
    lq.push_back(e);
  endtask

  // Returns shortly after edge k-1, i.e. "before edge k".
  task automatic at(input int k);
    while (cyc < k - 1) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  initial begin
    exp_level(3, 1'b0);
    at(3); rst_n = 1'b1;

    // Clean press, long press, repeats, glitch during long hold, release.
    exp_level(14, 1'b0);
    exp_strobe(15, S_PRESS); exp_level(15, 1'b1);
    exp_strobe(35, S_LONG);
    exp_strobe(40, S_REP); exp_strobe(45, S_REP); exp_strobe(50, S_REP);
    exp_level(55, 1'b1);
    exp_strobe(58, S_REP); exp_strobe(63, S_REP);
    exp_level(69, 1'b1);
    exp_strobe(70, S_REL); exp_level(70, 1'b0);
    at(10); btn_n = 1'b0;
    at(52); btn_n = 1'b1;
    at(54); btn_n = 1'b0;
    at(65); btn_n = 1'b1;

    // Press bounce: five 3-cycle low pulses, nothing accepted.
    exp_level(85, 1'b0); exp_level(100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      at(75 + 5 * i); btn_n = 1'b0;
      at(78 + 5 * i); btn_n = 1'b1;
    end

    // Release with two glitches before the long press.
    exp_strobe(110, S_PRESS); exp_level(127, 1'b1);
    exp_strobe(128, S_REL); exp_level(128, 1'b0);
    at(105); btn_n = 1'b0;
    at(115); btn_n = 1'b1;
    at(117); btn_n = 1'b0;
    at(119); btn_n = 1'b1;
    at(121); btn_n = 1'b0;
    at(123); btn_n = 1'b1;

    // Release sampled on the cycle the hold count reaches its terminal value.
    exp_strobe(140, S_PRESS); exp_level(159, 1'b1);
    exp_strobe(163, S_REL); exp_level(163, 1'b0);
    at(135); btn_n = 1'b0;
    at(158); btn_n = 1'b1;

    // Reset mid-debounce and mid-long with the button held throughout.
    exp_level(180, 1'b0);
    exp_strobe(181, S_PRESS); exp_level(181, 1'b1);
    exp_strobe(201, S_LONG); exp_strobe(206, S_REP);
    exp_strobe(216, S_PRESS); exp_strobe(236, S_LONG); exp_strobe(241, S_REP);
    exp_strobe(248, S_REL); exp_level(248, 1'b0);
    at(170); btn_n = 1'b0;
    at(174); rst_n = 1'b0;
    at(176); rst_n = 1'b1;
    at(209); rst_n = 1'b0;
    at(211); rst_n = 1'b1;
    at(243); btn_n = 1'b1;

    at(260); done = 1'b1;
  end

  initial begin
    while (!done && cyc < 1000) begin
      @(negedge clk);
      mon_s = {press_pulse, release_pulse, long_pulse, repeat_pulse};
      if (!rst_n) begin
        checks++;
        if ({pressed, mon_s} != 5'b0) begin
          errors++;
          $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc, {pressed, mon_s});
        end
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_strobe cyc=%0d got=none want=%b@%0d", cyc, sq[0].s, sq[0].cyc);
        void'(sq.pop_front());
      end
      if (mon_s != 4'b0) begin
        checks++;
        if (sq.size() == 0 || sq[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got=%b want=0000", cyc, mon_s);
        end else begin
          if (sq[0].s != mon_s) begin
            errors++;
            $display("FAIL strobe cyc=%0d got=%b want=%b", cyc, mon_s, sq[0].s);
          end
          void'(sq.pop_front());
        end
      end
      while (lq.size() > 0 && lq[0].cyc <= cyc) begin
        checks++;
        if (lq[0].cyc != cyc || pressed !== lq[0].v) begin
          errors++;
          $display("FAIL pressed_level cyc=%0d got=%b want=%b@%0d", cyc, pressed, lq[0].v, lq[0].cyc);
        end
        void'(lq.pop_front());
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout cyc=%0d got=running want=done", cyc);
    end
    while (sq.size() > 0) begin
      checks++; errors++;
      $display("FAIL missed_strobe_end got=none want=%b@%0d", sq[0].s, sq[0].cyc);
      void'(sq.pop_front());
    end
    while (lq.size() > 0) begin
      checks++; errors++;
      $display("FAIL unchecked_level got=none want=%b@%0d", lq[0].v, lq[0].cyc);
      void'(lq.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
